wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the core writeback path (ALU, PC+4, PC+IMM, IMM sources);
  - the data-memory load-return path, which has variable latency.
- Buffers load returns in a small FIFO.
- Arbitrates each cycle using load-first priority, with a starvation guard for the core.
- Registers the selected write onto rf_we/rf_waddr/rf_wdata. Sits between execute/memory and the register file.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_port_arbiter_if.sv | 42 ++++
 rtl/wb_ld_fifo.sv | 67 ++++++
 rtl/wb_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   XLEN       : default datapath width
//   REG_AW     : register-file address width
//   wb_sel_t   : writeback source encoding (WB_LOAD is never legal on the core path)
//   ld_entry_t : one buffered load return {rd, data}
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    WB_ALU   = 3'b000,
    WB_LOAD  = 3'b001,
    WB_PC4   = 3'b010,
    WB_PCIMM = 3'b011,
    WB_IMM   = 3'b100
  } wb_sel_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } ld_entry_t;

  // Sources the core writeback path may select. Loads arrive on their own port.
  function automatic logic core_sel_legal(input logic [2:0] sel);
    logic legal;
    case (sel)
      WB_ALU, WB_PC4, WB_PCIMM, WB_IMM: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the execute/memory stages and the writeback port arbiter.
//   core_* : core writeback request (valid/ready handshake, select, rd, candidate values)
//   ld_*   : load-return request (valid/ready handshake, rd, data)
//   rf_*   : registered register-file write port
//   err_sel: sticky illegal-select flag
// Modports: master = requester/observer side, slave = the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned XLEN = wb_pkg::XLEN
);

  logic            core_valid;
  logic            core_ready;
  logic [2:0]      core_sel;
  logic [4:0]      core_rd;
  logic [XLEN-1:0] core_alu;
  logic [XLEN-1:0] core_pc4;
  logic [XLEN-1:0] core_pcimm;
  logic [XLEN-1:0] core_imm;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            err_sel;

  modport master (
    output core_valid, core_sel, core_rd, core_alu, core_pc4, core_pcimm, core_imm,
    output ld_valid, ld_rd, ld_data,
    input  core_ready, ld_ready, rf_we, rf_waddr, rf_wdata, err_sel
  );

  modport slave (
    input  core_valid, core_sel, core_rd, core_alu, core_pc4, core_pcimm, core_imm,
    input  ld_valid, ld_rd, ld_data,
    output core_ready, ld_ready, rf_we, rf_waddr, rf_wdata, err_sel
  );

endinterface

// File: rtl/wb_ld_fifo.sv
// Synchronous FIFO holding load returns until they win the write port.
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_data : write one entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_data         : head entry, valid while !o_empty
//   o_full/o_empty : registered-state flags
// Depth must be a power of two so the pointers wrap naturally.
module wb_ld_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CountW = PtrW + 1;

  logic [Width-1:0]  r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CountW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CountW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountW'(1);
        2'b01:   r_count <= r_count - CountW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the core writeback path and the
// variable-latency load-return path. Loads are buffered in wb_ld_fifo and win arbitration
// by default; a wait counter force-grants the core after MAX_WAIT consecutive denials.
// The selected write is registered onto rf_we/rf_waddr/rf_wdata.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (core_*, ld_*, rf_*, err_sel)
// Optional feature: define WB_LD_BYPASS_EN to let a load arriving while the FIFO is empty
// skip the FIFO and be written one cycle after arrival.
// XLEN must match wb_pkg::XLEN since buffered entries use wb_pkg::ld_entry_t.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = wb_pkg::XLEN,
  parameter int unsigned LD_DEPTH = 2,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned WaitW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned EntryW  = $bits(ld_entry_t);

  // Registered state
  logic              r_we;
  logic [4:0]        r_waddr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_err_sel;
  logic [WaitW-1:0]  r_wait;

  // Combinational
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic [EntryW-1:0] w_fifo_rdata;
  ld_entry_t         w_push_entry;
  ld_entry_t         w_pop_entry;
  ld_entry_t         w_ld_entry;
  logic              w_wait_max;
  logic              w_core_force;
  logic              w_bypass;
  logic              w_grant_ld;
  logic              w_grant_core;
  logic              w_sel_legal;
  logic [XLEN-1:0]   w_core_data;
  logic              w_we_d;
  logic [4:0]        w_waddr_d;
  logic [XLEN-1:0]   w_wdata_d;
  logic [WaitW-1:0]  w_wait_d;

  assign w_push_entry.rd   = bus.ld_rd;
  assign w_push_entry.data = bus.ld_data;
  assign w_pop_entry       = ld_entry_t'(w_fifo_rdata);

  // Core has waited its limit and is still asking: it takes this cycle.
  assign w_wait_max   = (r_wait == WaitW'(MAX_WAIT));
  assign w_core_force = bus.core_valid && w_wait_max;

`ifdef WB_LD_BYPASS_EN
  // Empty FIFO implies not full, so the load is also being accepted on ld_ready.
  assign w_bypass = w_fifo_empty && bus.ld_valid && !w_core_force;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_pop   = !w_fifo_empty && !w_core_force;
  assign w_grant_ld   = w_fifo_pop || w_bypass;
  assign w_grant_core = bus.core_valid && !w_grant_ld;
  // ld_ready comes from the registered full flag only; a same-cycle pop frees nothing.
  assign w_fifo_push  = bus.ld_valid && !w_fifo_full && !w_bypass;
  assign w_ld_entry   = w_bypass ? w_push_entry : w_pop_entry;

  assign bus.ld_ready   = !w_fifo_full;
  assign bus.core_ready = w_grant_core;
  assign bus.rf_we      = r_we;
  assign bus.rf_waddr   = r_waddr;
  assign bus.rf_wdata   = r_wdata;
  assign bus.err_sel    = r_err_sel;

  wb_ld_fifo #(
    .Width (EntryW),
    .Depth (LD_DEPTH)
  ) u_ld_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_fifo_push),
    .i_data  (w_push_entry),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_sel_legal = core_sel_legal(bus.core_sel);

  always_comb begin
    w_core_data = '0;
    case (bus.core_sel)
      WB_ALU:   w_core_data = bus.core_alu;
      WB_PC4:   w_core_data = bus.core_pc4;
      WB_PCIMM: w_core_data = bus.core_pcimm;
      WB_IMM:   w_core_data = bus.core_imm;
      default:  w_core_data = '0;
    endcase
  end

  // Write-port next state. rd==0 and illegal selects consume the grant without writing.
  always_comb begin
    w_we_d    = 1'b0;
    w_waddr_d = r_waddr;
    w_wdata_d = r_wdata;
    if (w_grant_ld) begin
      w_we_d    = (w_ld_entry.rd != '0);
      w_waddr_d = w_ld_entry.rd;
      w_wdata_d = w_ld_entry.data;
    end else if (w_grant_core) begin
      w_we_d    = w_sel_legal && (bus.core_rd != '0);
      w_waddr_d = bus.core_rd;
      w_wdata_d = w_core_data;
    end
  end

  always_comb begin
    w_wait_d = '0;
    if (bus.core_valid && !w_grant_core) begin
      w_wait_d = w_wait_max ? r_wait : r_wait + WaitW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_err_sel <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_we    <= w_we_d;
      r_waddr <= w_waddr_d;
      r_wdata <= w_wdata_d;
      r_wait  <= w_wait_d;
      if (w_grant_core && !w_sel_legal) begin
        r_err_sel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus pushes the expected register-file
// writes, in hand-computed order, into exp_q; a negedge monitor pops and compares every
// cycle rf_we is high. Handshake and latency expectations are checked inline.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(
    .XLEN     (32),
    .LD_DEPTH (2),
    .MAX_WAIT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_exp;
  logic        acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_valid = 1'b0;
    bus.ld_valid   = 1'b0;
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: got rd=%0d data=0x%0h, want no write", bus.rf_waddr,
                 bus.rf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.rf_waddr, bus.rf_wdata} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_write: got rd=%0d data=0x%0h, want rd=%0d data=0x%0h",
                   bus.rf_waddr, bus.rf_wdata, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  // Loads L0..L4 (rd base+i) stream while the core (rd base+8) waits from the second cycle;
  // the core is denied three cycles and force-granted on the fourth.
  task automatic run_starve(input logic [4:0] base);
    for (int i = 0; i < 3; i++) begin
      exp_wr(base + 5'(i), 32'hA000_0000 + 32'(base) + 32'(i));
    end
`ifdef WB_LD_BYPASS_EN
    exp_wr(base + 5'd3, 32'hA000_0003 + 32'(base));
`endif
    exp_wr(base + 5'd8, 32'hC0DE_0000 + 32'(base));
    for (int c = 0; c < 5; c++) begin
      step();
      bus.ld_valid   = 1'b1;
      bus.ld_rd      = base + 5'(c);
      bus.ld_data    = 32'hA000_0000 + 32'(base) + 32'(c);
      bus.core_valid = (c != 0);
      bus.core_sel   = 3'b000;
      bus.core_rd    = base + 5'd8;
      bus.core_alu   = 32'hC0DE_0000 + 32'(base);
      @(negedge clk);
      chk1($sformatf("starve_ld_ready_c%0d", c), bus.ld_ready, 1'b1);
      if (c != 0) chk1($sformatf("starve_core_ready_c%0d", c), bus.core_ready, (c == 4));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_sel   = 3'b000;
    bus.core_rd    = 5'd0;
    bus.core_alu   = 32'h0000_1111;
    bus.core_pc4   = 32'h0000_2222;
    bus.core_pcimm = 32'h0000_1000;
    bus.core_imm   = 32'h0000_4444;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_data    = 32'h0;

    // Reset state
    step();
    step();
    @(negedge clk);
    chk1("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk1("rst_err_sel", bus.err_sel, 1'b0);
    chk1("rst_ld_ready", bus.ld_ready, 1'b1);
    chk1("rst_core_ready", bus.core_ready, 1'b0);
    step();
    rst_n = 1'b1;

    // Core only: every legal source, back to back
    step();
    bus.core_valid = 1'b1;
    bus.core_sel   = 3'b011;
    bus.core_rd    = 5'd5;
    exp_wr(5'd5, 32'h0000_1000);
    @(negedge clk);
    chk1("core_ready_pcimm", bus.core_ready, 1'b1);
    chk1("core_no_early_we", bus.rf_we, 1'b0);
    step();
    bus.core_sel = 3'b000;
    bus.core_rd  = 5'd6;
    exp_wr(5'd6, 32'h0000_1111);
    @(negedge clk);
    chk1("core_latency_we", bus.rf_we, 1'b1);
    step();
    bus.core_sel = 3'b010;
    bus.core_rd  = 5'd8;
    exp_wr(5'd8, 32'h0000_2222);
    step();
    bus.core_sel = 3'b100;
    bus.core_rd  = 5'd31;
    exp_wr(5'd31, 32'h0000_4444);
    step();
    idle();
    @(negedge clk);
    chk1("core_last_we", bus.rf_we, 1'b1);
    step();
    @(negedge clk);
    chk1("idle_no_we", bus.rf_we, 1'b0);
    chk("idle_hold_waddr", 64'(bus.rf_waddr), 64'd31);
    chk("idle_hold_wdata", 64'(bus.rf_wdata), 64'h4444);

    // Load only
    step();
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd7;
    bus.ld_data  = 32'h0000_DEAD;
    exp_wr(5'd7, 32'h0000_DEAD);
    @(negedge clk);
    chk1("ld_ready_empty", bus.ld_ready, 1'b1);
    chk1("ld_n0_we", bus.rf_we, 1'b0);
    step();
    idle();
    @(negedge clk);
`ifdef WB_LD_BYPASS_EN
    chk1("ld_n1_we", bus.rf_we, 1'b1);
`else
    chk1("ld_n1_we", bus.rf_we, 1'b0);
`endif
    step();
    @(negedge clk);
`ifdef WB_LD_BYPASS_EN
    chk1("ld_n2_we", bus.rf_we, 1'b0);
`else
    chk1("ld_n2_we", bus.rf_we, 1'b1);
`endif
    step();

    // Starvation guard, then the FIFO fills and a sixth load waits for a pop
    run_starve(5'd1);
`ifndef WB_LD_BYPASS_EN
    exp_wr(5'd4, 32'hA000_0004);
`endif
    exp_wr(5'd5, 32'hA000_0005);
    exp_wr(5'd6, 32'hA000_0006);
    step();
    bus.core_valid = 1'b0;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd6;
    bus.ld_data    = 32'hA000_0006;
    @(negedge clk);
`ifdef WB_LD_BYPASS_EN
    chk1("full_ld_ready", bus.ld_ready, 1'b1);
`else
    chk1("full_ld_ready", bus.ld_ready, 1'b0);
`endif
    acc = bus.ld_ready;
    if (!acc) begin
      step();
      @(negedge clk);
      chk1("full_ld_ready_after_pop", bus.ld_ready, 1'b1);
    end
    step();
    idle();
    repeat (6) step();
    chk("starve_drain", 64'(exp_q.size()), 64'd0);

    // Illegal selects and rd==0
    step();
    bus.core_valid = 1'b1;
    bus.core_sel   = 3'b001;
    bus.core_rd    = 5'd3;
    @(negedge clk);
    chk1("ill001_ready", bus.core_ready, 1'b1);
    chk1("ill001_err_before", bus.err_sel, 1'b0);
    step();
    bus.core_sel = 3'b111;
    bus.core_rd  = 5'd4;
    @(negedge clk);
    chk1("ill111_ready", bus.core_ready, 1'b1);
    chk1("ill001_no_we", bus.rf_we, 1'b0);
    chk1("ill001_err", bus.err_sel, 1'b1);
    step();
    bus.core_sel = 3'b000;
    bus.core_rd  = 5'd0;
    @(negedge clk);
    chk1("rd0_ready", bus.core_ready, 1'b1);
    chk1("ill111_no_we", bus.rf_we, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk1("rd0_no_we", bus.rf_we, 1'b0);
    chk1("err_sticky", bus.err_sel, 1'b1);
    step();

    // Reset with loads still buffered: nothing stale may come out afterwards
    run_starve(5'd16);
    step();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_we", bus.rf_we, 1'b0);
    chk1("post_rst_ld_ready", bus.ld_ready, 1'b1);
    chk1("post_rst_err", bus.err_sel, 1'b0);
    repeat (5) step();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
